// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_if
// Brief  : Hazard/branch/halt inputs and stall/flush/counter outputs of
//          the pipeline controller.
// Rev    : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if;
  logic [4:0]  ID_rs1_i;
  logic [4:0]  ID_rs2_i;
  logic [4:0]  EX_rd_i;
  logic        EX_MemRead_i;
  logic        branch_taken_i;
  logic        halt_req_i;
  logic        clr_cnt_i;
  logic        PCWrite_o;
  logic        IFID_Write_o;
  logic        IFID_Flush_o;
  logic        NoOp_o;
  logic        halt_ack_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  // Pipeline side: drives the status inputs, consumes the controls.
  modport master (
    output ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, branch_taken_i,
           halt_req_i, clr_cnt_i,
    input  PCWrite_o, IFID_Write_o, IFID_Flush_o, NoOp_o, halt_ack_o,
           stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, branch_taken_i,
           halt_req_i, clr_cnt_i,
    output PCWrite_o, IFID_Write_o, IFID_Flush_o, NoOp_o, halt_ack_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Load-use stall, branch flush and debug halt/drain control with
//          saturating stall/flush performance counters.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_ctrl (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [15:0] c_cnt_max    = 16'hFFFF;
  localparam logic [1:0]  c_drain_load = 2'd2;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_drain_cnt;
  logic [1:0]  w_drain_cnt_next;
  logic        r_halt_ack;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_hazard;
  logic        w_stall;
  logic        w_pc_write;
  logic        w_ifid_write;
  logic        w_ifid_flush;
  logic        w_noop;

  // A load into x0 never produces a usable value, so it cannot cause a hazard.
  assign w_hazard = bus.EX_MemRead_i && (bus.EX_rd_i != 5'd0) &&
                    ((bus.EX_rd_i == bus.ID_rs1_i) || (bus.EX_rd_i == bus.ID_rs2_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_RUN;
      r_drain_cnt <= 2'd0;
      r_halt_ack  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
      r_halt_ack  <= (w_state_next == S_HALTED);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    w_stall          = 1'b0;
    w_pc_write       = 1'b1;
    w_ifid_write     = 1'b1;
    w_ifid_flush     = 1'b0;
    w_noop           = 1'b0;
    case (r_state)
      S_RUN: begin
        // Stall beats branch: branch operands are stale while a load is pending.
        if (w_hazard) begin
          w_stall      = 1'b1;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_noop       = 1'b1;
        end else if (bus.branch_taken_i) begin
          w_ifid_flush = 1'b1;
        end
        if (bus.halt_req_i) begin
          w_state_next     = S_DRAIN;
          w_drain_cnt_next = c_drain_load;
        end
      end
      S_DRAIN: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_noop       = 1'b1;
        if (!bus.halt_req_i) begin
          w_state_next     = S_RUN;
          w_drain_cnt_next = 2'd0;
        end else if (r_drain_cnt == 2'd0) begin
          w_state_next = S_HALTED;
        end else begin
          w_drain_cnt_next = r_drain_cnt - 2'd1;
        end
      end
      S_HALTED: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_noop       = 1'b1;
        if (!bus.halt_req_i) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next     = S_RUN;
        w_drain_cnt_next = 2'd0;
      end
    endcase
  end

  // Clear wins over any increment in the same cycle; both counters stick at max.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else if (bus.clr_cnt_i) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_ifid_flush && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.PCWrite_o    = w_pc_write;
  assign bus.IFID_Write_o = w_ifid_write;
  assign bus.IFID_Flush_o = w_ifid_flush;
  assign bus.NoOp_o       = w_noop;
  assign bus.halt_ack_o   = r_halt_ack;
  assign bus.stall_cnt_o  = r_stall_cnt;
  assign bus.flush_cnt_o  = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports ID_rs1_i and ID_rs2_i, input, 5 bits each: source register IDs of the instruction in ID.
REQ-004 SHALL have ports EX_rd_i (input, 5 bits) and EX_MemRead_i (input, 1 bit): destination register and load flag of the instruction in EX.
REQ-005 SHALL have port branch_taken_i, input, 1 bit: the branch in ID resolved taken this cycle.
REQ-006 SHALL have ports halt_req_i (input, 1 bit), a debug halt request held high until released, and clr_cnt_i (input, 1 bit), a synchronous counter clear.
REQ-007 SHALL have port PCWrite_o, output, 1 bit: PC update enable.
REQ-008 SHALL have port IFID_Write_o, output, 1 bit: IF_ID write enable.
REQ-009 SHALL have port IFID_Flush_o, output, 1 bit: clear IF_ID to a bubble.
REQ-010 SHALL have port NoOp_o, output, 1 bit: zero the ID_EX control fields at the next edge.
REQ-011 SHALL have port halt_ack_o, output, 1 bit, registered: pipeline drained and halted.
REQ-012 SHALL have ports stall_cnt_o and flush_cnt_o, output, 16 bits each: performance counters.

Function
REQ-013 SHALL implement FSM states RUN, DRAIN and HALTED, plus a 2-bit drain counter.
REQ-014 SHALL define hazard = EX_MemRead_i & (EX_rd_i != 0) & (EX_rd_i == ID_rs1_i | EX_rd_i == ID_rs2_i).
REQ-015 In RUN with hazard=1, SHALL drive PCWrite_o=0, IFID_Write_o=0, NoOp_o=1 and IFID_Flush_o=0, combinationally in the same cycle.
REQ-016 In RUN with hazard=0 and branch_taken_i=1, SHALL drive IFID_Flush_o=1, with PCWrite_o=1, IFID_Write_o=1 and NoOp_o=0.
REQ-017 When hazard and branch_taken_i are both 1, the stall SHALL win and branch_taken_i SHALL be ignored, because the branch operands are invalid.
REQ-018 In RUN with neither condition, SHALL drive PCWrite_o=1, IFID_Write_o=1, NoOp_o=0 and IFID_Flush_o=0.
REQ-019 RUN with halt_req_i=1 at an edge SHALL go to DRAIN and load the drain counter with 2; the outputs in that RUN cycle SHALL follow REQ-015 to REQ-018.
REQ-020 In DRAIN and HALTED, SHALL drive PCWrite_o=0, IFID_Write_o=0, NoOp_o=1 and IFID_Flush_o=0; branch_taken_i and hazard SHALL be ignored.
REQ-021 DRAIN SHALL decrement the counter each cycle and go to HALTED at the edge where the counter is 0, giving exactly 3 DRAIN cycles.
REQ-022 If halt_req_i=0 in DRAIN, SHALL return to RUN at the next edge, with no ack.
REQ-023 halt_ack_o SHALL be 1 only while in HALTED.
REQ-024 HALTED with halt_req_i=0 SHALL return to RUN at the next edge; the instruction held in IF_ID then re-issues.
REQ-025 stall_cnt_o SHALL increment once per cycle in which REQ-015 applies.
REQ-026 flush_cnt_o SHALL increment once per cycle in which IFID_Flush_o=1.
REQ-027 Both counters SHALL saturate at 0xFFFF without wrapping.
REQ-028 clr_cnt_i=1 SHALL zero both counters at the next edge, with priority over any increment in the same cycle.

Reset
REQ-029 rst_i=0 SHALL immediately force state RUN, drain counter 0, halt_ack_o=0, stall_cnt_o=0 and flush_cnt_o=0, including mid-DRAIN or in HALTED.
REQ-030 While in reset with hazard and branch inputs low, SHALL drive PCWrite_o=1, IFID_Write_o=1, NoOp_o=0 and IFID_Flush_o=0.
REQ-031 Release of reset SHALL resume normal operation in RUN at the first rising clk_i.

Verification
REQ-032 Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs2_i=5 for 1 cycle -> PCWrite_o=0, IFID_Write_o=0, NoOp_o=1 that cycle; stall_cnt_o=1.
REQ-033 rd=x0 and branch priority: EX_rd_i=0 matching rs1 -> no stall; hazard together with branch_taken_i=1 -> stall, IFID_Flush_o=0, flush_cnt_o unchanged.
REQ-034 Halt: halt_req_i=1 from cycle 0 -> DRAIN in cycles 1-3, halt_ack_o=1 from cycle 4; release halt_req_i -> RUN one cycle later, PCWrite_o=1.
REQ-035 Abort: halt_req_i dropped in the 2nd DRAIN cycle -> RUN next cycle, halt_ack_o never 1.
REQ-036 Saturation and clear: 65540 stall cycles -> stall_cnt_o=0xFFFF; clr_cnt_i=1 together with a stall -> 0.
REQ-037 Async reset: rst_i=0 asserted in HALTED between clock edges -> halt_ack_o=0 and counters 0 before the next edge.
